// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types for the two-master AXI4-Lite arbiter
package axi_arb_pkg;
    localparam int NUM_MASTERS = 2;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA} state_t;

    // 0 selects m0, 1 selects m1
    typedef logic owner_t;
endpackage

// File: rtl/axi_interf.sv
// rtl/axi_interf.sv - AXI4-Lite signal bundle with master/slave views
interface axi_interf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  owner_t                 last,
    output logic                   gnt_valid,
    output owner_t                 gnt_idx
);
    // On a tie the requester that was not served last wins.
    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/axi_lite_arbiter2.sv
// rtl/axi_lite_arbiter2.sv - two-master to one-slave AXI4-Lite arbiter, one transaction per grant
module axi_lite_arbiter2
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    axi_interf.slave   m0_axi,
    axi_interf.slave   m1_axi,
    axi_interf.master  s_axi,
    output logic [1:0] grant,
    output logic       busy
);
    state_t state, state_nxt;
    owner_t owner, owner_nxt, last, last_nxt;
    logic   aw_done, aw_done_nxt, w_done, w_done_nxt;

    logic [NUM_MASTERS-1:0] req;
    logic                   gnt_valid;
    owner_t                 gnt_idx;
    logic                   active, own0, own1;

    assign req = {m1_axi.awvalid | m1_axi.arvalid, m0_axi.awvalid | m0_axi.arvalid};

    rr_arb2 u_rr_arb2 (
        .req       (req),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Owner-selected master signals
    logic                    sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [ADDR_WIDTH-1:0]   sel_awaddr, sel_araddr;
    logic [2:0]              sel_awprot, sel_arprot;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_wstrb;
    logic                    gnt_awvalid;

    assign sel_awvalid = owner ? m1_axi.awvalid : m0_axi.awvalid;
    assign sel_wvalid  = owner ? m1_axi.wvalid  : m0_axi.wvalid;
    assign sel_bready  = owner ? m1_axi.bready  : m0_axi.bready;
    assign sel_arvalid = owner ? m1_axi.arvalid : m0_axi.arvalid;
    assign sel_rready  = owner ? m1_axi.rready  : m0_axi.rready;
    assign sel_awaddr  = owner ? m1_axi.awaddr  : m0_axi.awaddr;
    assign sel_araddr  = owner ? m1_axi.araddr  : m0_axi.araddr;
    assign sel_awprot  = owner ? m1_axi.awprot  : m0_axi.awprot;
    assign sel_arprot  = owner ? m1_axi.arprot  : m0_axi.arprot;
    assign sel_wdata   = owner ? m1_axi.wdata   : m0_axi.wdata;
    assign sel_wstrb   = owner ? m1_axi.wstrb   : m0_axi.wstrb;
    assign gnt_awvalid = gnt_idx ? m1_axi.awvalid : m0_axi.awvalid;

    // Slave-facing valids/readies, gated so each beat is issued exactly once
    logic fwd_awvalid, fwd_wvalid, fwd_bready, fwd_arvalid, fwd_rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign active      = (state != IDLE);
    assign own0        = active & ~owner;
    assign own1        = active & owner;
    assign fwd_awvalid = (state == WR) & ~aw_done & sel_awvalid;
    assign fwd_wvalid  = (state == WR) & ~w_done & sel_wvalid;
    assign fwd_bready  = (state == WR_RESP) & sel_bready;
    assign fwd_arvalid = (state == RD) & sel_arvalid;
    assign fwd_rready  = (state == RD_DATA) & sel_rready;

    assign aw_hs = fwd_awvalid & s_axi.awready;
    assign w_hs  = fwd_wvalid & s_axi.wready;
    assign b_hs  = fwd_bready & s_axi.bvalid;
    assign ar_hs = fwd_arvalid & s_axi.arready;
    assign r_hs  = fwd_rready & s_axi.rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    owner_nxt   = gnt_idx;
                    last_nxt    = gnt_idx;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = gnt_awvalid ? WR : RD;
                end
            end
            WR: begin
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: if (b_hs) state_nxt = IDLE;
            RD:      if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axi.awvalid = fwd_awvalid;
    assign s_axi.wvalid  = fwd_wvalid;
    assign s_axi.bready  = fwd_bready;
    assign s_axi.arvalid = fwd_arvalid;
    assign s_axi.rready  = fwd_rready;
    assign s_axi.awaddr  = active ? sel_awaddr : '0;
    assign s_axi.awprot  = active ? sel_awprot : '0;
    assign s_axi.wdata   = active ? sel_wdata  : '0;
    assign s_axi.wstrb   = active ? sel_wstrb  : '0;
    assign s_axi.araddr  = active ? sel_araddr : '0;
    assign s_axi.arprot  = active ? sel_arprot : '0;

    // Responses are broadcast; only the owner ever sees a valid or ready
    assign m0_axi.awready = own0 & (state == WR) & ~aw_done & s_axi.awready;
    assign m0_axi.wready  = own0 & (state == WR) & ~w_done & s_axi.wready;
    assign m0_axi.bvalid  = own0 & (state == WR_RESP) & s_axi.bvalid;
    assign m0_axi.arready = own0 & (state == RD) & s_axi.arready;
    assign m0_axi.rvalid  = own0 & (state == RD_DATA) & s_axi.rvalid;
    assign m0_axi.bresp   = s_axi.bresp;
    assign m0_axi.rdata   = s_axi.rdata;
    assign m0_axi.rresp   = s_axi.rresp;

    assign m1_axi.awready = own1 & (state == WR) & ~aw_done & s_axi.awready;
    assign m1_axi.wready  = own1 & (state == WR) & ~w_done & s_axi.wready;
    assign m1_axi.bvalid  = own1 & (state == WR_RESP) & s_axi.bvalid;
    assign m1_axi.arready = own1 & (state == RD) & s_axi.arready;
    assign m1_axi.rvalid  = own1 & (state == RD_DATA) & s_axi.rvalid;
    assign m1_axi.bresp   = s_axi.bresp;
    assign m1_axi.rdata   = s_axi.rdata;
    assign m1_axi.rresp   = s_axi.rresp;

    assign grant = {own1, own0};
    assign busy  = active;
endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// tb/tb_axi_lite_arbiter2.sv - scoreboard bench for the two-master AXI4-Lite arbiter
module tb_axi_lite_arbiter2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       busy;

    axi_interf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    axi_interf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    axi_interf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi_lite_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .m0_axi (m0_if),
        .m1_axi (m1_if),
        .s_axi  (s_if),
        .grant  (grant),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Master-side drive/observe arrays, indexed by master number
    logic [31:0] mv_awaddr[2], mv_wdata[2], mv_araddr[2];
    logic [3:0]  mv_wstrb[2];
    logic        mv_awvalid[2], mv_wvalid[2], mv_bready[2], mv_arvalid[2], mv_rready[2];
    logic        mr_awready[2], mr_wready[2], mr_bvalid[2], mr_arready[2], mr_rvalid[2];
    logic [31:0] mr_rdata[2];

    assign m0_if.awaddr = mv_awaddr[0];  assign m1_if.awaddr = mv_awaddr[1];
    assign m0_if.wdata  = mv_wdata[0];   assign m1_if.wdata  = mv_wdata[1];
    assign m0_if.wstrb  = mv_wstrb[0];   assign m1_if.wstrb  = mv_wstrb[1];
    assign m0_if.araddr = mv_araddr[0];  assign m1_if.araddr = mv_araddr[1];
    assign m0_if.awvalid = mv_awvalid[0]; assign m1_if.awvalid = mv_awvalid[1];
    assign m0_if.wvalid  = mv_wvalid[0];  assign m1_if.wvalid  = mv_wvalid[1];
    assign m0_if.bready  = mv_bready[0];  assign m1_if.bready  = mv_bready[1];
    assign m0_if.arvalid = mv_arvalid[0]; assign m1_if.arvalid = mv_arvalid[1];
    assign m0_if.rready  = mv_rready[0];  assign m1_if.rready  = mv_rready[1];
    assign m0_if.awprot = 3'b001; assign m1_if.awprot = 3'b010;
    assign m0_if.arprot = 3'b001; assign m1_if.arprot = 3'b010;
    assign mr_awready[0] = m0_if.awready; assign mr_awready[1] = m1_if.awready;
    assign mr_wready[0]  = m0_if.wready;  assign mr_wready[1]  = m1_if.wready;
    assign mr_bvalid[0]  = m0_if.bvalid;  assign mr_bvalid[1]  = m1_if.bvalid;
    assign mr_arready[0] = m0_if.arready; assign mr_arready[1] = m1_if.arready;
    assign mr_rvalid[0]  = m0_if.rvalid;  assign mr_rvalid[1]  = m1_if.rvalid;
    assign mr_rdata[0]   = m0_if.rdata;   assign mr_rdata[1]   = m1_if.rdata;

    // Scoreboard queues
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;
    wr_t         exp_wr[2][$];
    logic [31:0] exp_rd[2][$];
    logic [1:0]  exp_gnt[$];

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    // Slave model: readies after a programmable wait, one response per request
    int   aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int   aw_beats = 0, w_beats = 0;
    bit   aw_got = 0, w_got = 0, b_pend = 0, hold_b = 0;
    logic [31:0] got_addr, got_data;
    logic [3:0]  got_strb;

    assign s_if.awready = s_if.awvalid && !aw_got && (aw_wait >= aw_delay);
    assign s_if.wready  = s_if.wvalid && !w_got && (w_wait >= w_delay);
    assign s_if.arready = s_if.arvalid && !s_if.rvalid;
    assign s_if.bresp   = 2'b00;
    assign s_if.rresp   = 2'b00;

    initial begin
        bit awh, wh, bh, arh, rh, awv, wv, rst_s, own;
        logic [31:0] sa, sd, sra;
        logic [3:0]  ss;
        wr_t e;
        s_if.bvalid = 1'b0;
        s_if.rvalid = 1'b0;
        s_if.rdata  = '0;
        forever begin
            @(negedge clk);
            awh = s_if.awvalid & s_if.awready;
            wh  = s_if.wvalid & s_if.wready;
            bh  = s_if.bvalid & s_if.bready;
            arh = s_if.arvalid & s_if.arready;
            rh  = s_if.rvalid & s_if.rready;
            awv = s_if.awvalid; wv = s_if.wvalid;
            sa = s_if.awaddr; sd = s_if.wdata; ss = s_if.wstrb; sra = s_if.araddr;
            own = grant[1];
            rst_s = reset;
            @(posedge clk);
            #1;
            if (rst_s) begin
                aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
                s_if.bvalid = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
                continue;
            end
            if (awh) begin aw_got = 1; got_addr = sa; aw_beats++; aw_wait = 0; end
            else if (awv) aw_wait++;
            if (wh) begin w_got = 1; got_data = sd; got_strb = ss; w_beats++; w_wait = 0; end
            else if (wv) w_wait++;
            if (aw_got && w_got) begin
                if (exp_wr[own].size() == 0) check("wr_unexpected", {31'd0, own}, 64'hFF);
                else begin
                    e = exp_wr[own].pop_front();
                    check("wr_addr", got_addr, e.a);
                    check("wr_data", got_data, e.d);
                    check("wr_strb", got_strb, e.s);
                end
                mem[got_addr] = got_data;
                aw_got = 0; w_got = 0; b_pend = 1;
            end
            if (bh) s_if.bvalid = 1'b0;
            if (b_pend && !hold_b && !s_if.bvalid) begin s_if.bvalid = 1'b1; b_pend = 0; end
            if (rh) s_if.rvalid = 1'b0;
            if (arh) begin s_if.rvalid = 1'b1; s_if.rdata = rd_model(sra); end
        end
    end

    // Monitor: grant order, idle gap, and a quiet non-owner every cycle
    logic [1:0] prev_grant = 2'b00;
    int idle_cnt = 0;
    bit check_gap = 0, seen_txn = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_grant == 2'b00 && grant != 2'b00) begin
                if (check_gap && seen_txn) check("idle_gap", idle_cnt, 1);
                seen_txn = 1;
                idle_cnt = 0;
                if (exp_gnt.size() != 0) check("gnt_order", grant, exp_gnt.pop_front());
                else check("gnt_unexpected", grant, 2'b00);
            end else if (grant == 2'b00) idle_cnt++;
            check("busy_vs_grant", busy, grant != 2'b00);
            for (int m = 0; m < 2; m++)
                if (!grant[m])
                    check($sformatf("nonowner_quiet_m%0d", m),
                          {mr_awready[m], mr_wready[m], mr_arready[m], mr_bvalid[m], mr_rvalid[m]}, 0);
            prev_grant = grant;
        end
    end

    task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit wait_b);
        int  n = 0;
        bit  awh, wh, bh;
        mv_awaddr[m] = a; mv_wdata[m] = d; mv_wstrb[m] = s;
        mv_awvalid[m] = 1'b1; mv_wvalid[m] = 1'b1; mv_bready[m] = wait_b;
        exp_wr[m].push_back('{a: a, d: d, s: s});
        forever begin
            @(negedge clk);
            awh = mv_awvalid[m] & mr_awready[m];
            wh  = mv_wvalid[m] & mr_wready[m];
            bh  = mr_bvalid[m] & mv_bready[m];
            @(posedge clk);
            #1;
            if (awh) mv_awvalid[m] = 1'b0;
            if (wh)  mv_wvalid[m]  = 1'b0;
            if (bh) begin mv_bready[m] = 1'b0; break; end
            if (!wait_b && !mv_awvalid[m] && !mv_wvalid[m]) break;
            if (++n > 300) begin
                check($sformatf("wr_timeout_m%0d", m), 0, 1);
                mv_awvalid[m] = 1'b0; mv_wvalid[m] = 1'b0; mv_bready[m] = 1'b0;
                break;
            end
        end
    endtask

    task automatic mread(input int m, input logic [31:0] a, input int hold);
        int  n = 0, hc = 0;
        bit  arh, rv, seen = 0;
        logic [31:0] first = '0;
        mv_araddr[m] = a; mv_arvalid[m] = 1'b1; mv_rready[m] = (hold == 0);
        exp_rd[m].push_back(rd_model(a));
        forever begin
            @(negedge clk);
            arh = mv_arvalid[m] & mr_arready[m];
            rv  = mr_rvalid[m];
            if (rv && mv_rready[m]) begin
                if (exp_rd[m].size() != 0) check($sformatf("rdata_m%0d", m), mr_rdata[m], exp_rd[m].pop_front());
                else check("rd_unexpected", mr_rdata[m], 0);
                @(posedge clk);
                #1;
                mv_rready[m] = 1'b0;
                break;
            end
            if (seen) begin
                check("rvalid_held", rv, 1);
                check("rdata_stable", mr_rdata[m], first);
            end else if (rv) begin
                seen = 1;
                first = mr_rdata[m];
            end
            if (seen) hc++;
            @(posedge clk);
            #1;
            if (arh) mv_arvalid[m] = 1'b0;
            if (seen && hc >= hold) mv_rready[m] = 1'b1;
            if (++n > 300) begin
                check($sformatf("rd_timeout_m%0d", m), 0, 1);
                mv_arvalid[m] = 1'b0; mv_rready[m] = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0;
        for (int m = 0; m < 2; m++) begin
            mv_awaddr[m] = '0; mv_wdata[m] = '0; mv_wstrb[m] = '0; mv_araddr[m] = '0;
            mv_awvalid[m] = 0; mv_wvalid[m] = 0; mv_bready[m] = 0; mv_arvalid[m] = 0; mv_rready[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready}, 0);
        check("rst_s_payload", {s_if.awaddr, s_if.wdata}, 0);
        do_reset();

        // m0 single write, slave ready immediately
        exp_gnt.push_back(2'b01);
        fork
            mwrite(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1);
            begin
                @(negedge clk);
                check("t1_awvalid_idle", s_if.awvalid, 0);
                @(negedge clk);
                check("t1_awvalid_fwd", s_if.awvalid, 1);
                check("t1_grant", grant, 2'b01);
                check("t1_awaddr", s_if.awaddr, 32'h10);
                check("t1_wdata", s_if.wdata, 32'hDEAD_BEEF);
                check("t1_awprot", s_if.awprot, 3'b001);
                @(negedge clk);
                check("t1_bvalid", mr_bvalid[0], 1);
                check("t1_awvalid_gated", s_if.awvalid, 0);
                @(negedge clk);
                check("t1_grant_idle", grant, 2'b00);
            end
        join

        // simultaneous reads from reset: m0 first
        do_reset();
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        fork
            mread(0, 32'h100, 0);
            mread(1, 32'h200, 0);
        join

        // continuous contention: strict alternation, one idle cycle between
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(2'b01);
            exp_gnt.push_back(2'b10);
        end
        seen_txn = 0;
        check_gap = 1;
        fork
            for (int i = 0; i < 4; i++) mwrite(0, 32'h1000 + i * 4, 32'hA000_0000 + i, 4'hF, 1);
            for (int i = 0; i < 4; i++) mwrite(1, 32'h2000 + i * 4, 32'hB000_0000 + i, 4'(i + 1), 1);
        join
        check_gap = 0;
        check("t3_mem_m0", mem[32'h100C], 32'hA000_0003);
        check("t3_mem_m1", mem[32'h2008], 32'hB000_0002);

        // split AW/W: awready three cycles ahead of wready
        aw0 = aw_beats; w0 = w_beats;
        w_delay = 3;
        exp_gnt.push_back(2'b01);
        fork
            mwrite(0, 32'h400, 32'h1234_5678, 4'h3, 1);
            begin
                @(negedge clk);
                @(negedge clk);
                check("t4_awvalid_first", s_if.awvalid, 1);
                repeat (3) begin
                    @(negedge clk);
                    check("t4_awvalid_dropped", s_if.awvalid, 0);
                    check("t4_wvalid_held", s_if.wvalid, 1);
                    check("t4_not_wr_resp", s_if.bready, 0);
                end
                @(negedge clk);
                check("t4_wr_resp", s_if.bready, 1);
            end
        join
        w_delay = 0;
        check("t4_aw_beats", aw_beats - aw0, 1);
        check("t4_w_beats", w_beats - w0, 1);

        // read backpressure on m1 with an m0 read waiting
        exp_gnt.push_back(2'b10);
        exp_gnt.push_back(2'b01);
        fork
            mread(1, 32'h500, 5);
            begin
                repeat (3) @(posedge clk);
                #1;
                mread(0, 32'h600, 0);
            end
            begin
                repeat (6) @(negedge clk);
                check("t5_grant_held", grant, 2'b10);
            end
        join

        // reset while in WR_RESP
        do_reset();
        hold_b = 1;
        exp_gnt.push_back(2'b01);
        mwrite(0, 32'h700, 32'h0BAD_F00D, 4'hF, 0);
        @(negedge clk);
        check("t6_in_wr_resp", grant, 2'b01);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_grant", grant, 2'b00);
        check("t6_busy", busy, 0);
        check("t6_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready}, 0);
        check("t6_m0_quiet", {mr_awready[0], mr_wready[0], mr_bvalid[0], mr_arready[0], mr_rvalid[0]}, 0);
        reset = 1'b0;
        hold_b = 0;
        exp_gnt.push_back(2'b10);
        mread(1, 32'h300, 0);

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_empty", exp_wr[0].size() + exp_wr[1].size(), 0);
        check("rd_queue_empty", exp_rd[0].size() + exp_rd[1].size(), 0);
        check("gnt_queue_empty", exp_gnt.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
